insulin_dose_controller: RTL and testbench

Sequential stage directly downstream of the glycemic index calculator. Samples the 4-bit `glycemicIndex` on a valid strobe, confirms an out-of-range condition over two consecutive samples, then drives a timed insulin or glucagon pump pulse sized from the index. After each dose it enforces a lockout window. It also maintains a saturating dose counter and a level alarm.

---
 rtl/insulin_dose_controller_if.sv | 20 ++
 rtl/insulin_dose_controller.sv | 111 +++++++++++
 tb/tb_insulin_dose_controller.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/insulin_dose_controller_if.sv
// Sample/pump bus between the glycemic index calculator, the dose controller and the pumps.
interface insulin_dose_controller_if;
    logic [3:0] glycemicIndex;
    logic       sampleValid;
    logic       insulinPump;
    logic       glucagonPump;
    logic       busy;
    logic       alarm;
    logic [7:0] doseCount;

    modport master (
        output glycemicIndex, sampleValid,
        input  insulinPump, glucagonPump, busy, alarm, doseCount
    );

    modport slave (
        input  glycemicIndex, sampleValid,
        output insulinPump, glucagonPump, busy, alarm, doseCount
    );
endinterface

// File: rtl/insulin_dose_controller.sv
// Confirms an out-of-range glycemic index over two samples, drives a sized pump pulse,
// then holds off new doses for a lockout window. Also keeps a dose count and a level alarm.
module insulin_dose_controller #(
    parameter int HIGH_TH    = 12,
    parameter int LOW_TH     = 3,
    parameter int PULSE_UNIT = 4,
    parameter int LOCKOUT    = 16
) (
    input logic                        clk,
    input logic                        reset,
    insulin_dose_controller_if.slave   bus
);
    localparam logic [7:0] HI8   = 8'(HIGH_TH);
    localparam logic [7:0] LO8   = 8'(LOW_TH);
    localparam logic [7:0] PU8   = 8'(PULSE_UNIT);
    localparam logic [7:0] LOCK8 = 8'(LOCKOUT);

    typedef enum logic [1:0] {IDLE, ARMED, DOSE, LOCKOUT_ST} state_t;

    state_t     state_q;
    logic       cls_high_q;
    logic [7:0] timer_q;
    logic       insulin_q, glucagon_q, busy_q, alarm_q;
    logic [7:0] dose_count_q;

    logic [7:0] idx8;
    logic       is_high, is_low, is_normal;
    logic [7:0] dose_len_d;
    logic       alarm_d;

    always_comb begin
        idx8      = {4'd0, bus.glycemicIndex};
        is_high   = (idx8 >= HI8);
        is_low    = (idx8 <= LO8);
        is_normal = !is_high && !is_low;
        // Only meaningful when the sample is out of range; the NORMAL case is never used.
        dose_len_d = is_high ? 8'((idx8 - HI8 + 8'd1) * PU8)
                             : 8'((LO8 - idx8 + 8'd1) * PU8);
        alarm_d = alarm_q;
        if (bus.sampleValid) begin
            if (bus.glycemicIndex == 4'd0 || bus.glycemicIndex == 4'd15) alarm_d = 1'b1;
            else if (is_normal)                                          alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cls_high_q   <= 1'b0;
            timer_q      <= 8'd0;
            insulin_q    <= 1'b0;
            glucagon_q   <= 1'b0;
            busy_q       <= 1'b0;
            alarm_q      <= 1'b0;
            dose_count_q <= 8'd0;
        end else begin
            alarm_q <= alarm_d;
            case (state_q)
                IDLE: begin
                    if (bus.sampleValid && !is_normal) begin
                        state_q    <= ARMED;
                        cls_high_q <= is_high;
                    end
                end
                ARMED: begin
                    if (bus.sampleValid) begin
                        if (is_normal) begin
                            state_q <= IDLE;
                        end else if (is_high == cls_high_q) begin
                            state_q    <= DOSE;
                            timer_q    <= dose_len_d;
                            insulin_q  <= is_high;
                            glucagon_q <= !is_high;
                            busy_q     <= 1'b1;
                            if (dose_count_q != 8'hFF) dose_count_q <= dose_count_q + 8'd1;
                        end else begin
                            cls_high_q <= is_high;
                        end
                    end
                end
                DOSE: begin
                    // Timer counts down to 1 so the pump spans exactly dose-length cycles.
                    if (timer_q == 8'd1) begin
                        state_q    <= LOCKOUT_ST;
                        timer_q    <= LOCK8;
                        insulin_q  <= 1'b0;
                        glucagon_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end
                LOCKOUT_ST: begin
                    if (timer_q == 8'd1) begin
                        state_q <= IDLE;
                        timer_q <= 8'd0;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.insulinPump  = insulin_q;
    assign bus.glucagonPump = glucagon_q;
    assign bus.busy         = busy_q;
    assign bus.alarm        = alarm_q;
    assign bus.doseCount    = dose_count_q;
endmodule

// File: tb/tb_insulin_dose_controller.sv
// Directed bench for insulin_dose_controller with default parameters (12/3/4/16).
module tb_insulin_dose_controller;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    insulin_dose_controller_if bus();

    insulin_dose_controller #(
        .HIGH_TH(12), .LOW_TH(3), .PULSE_UNIT(4), .LOCKOUT(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Strobe one sample on the next rising edge; returns 1 time unit after that edge.
    task automatic sample(input logic [3:0] v);
        @(negedge clk);
        bus.glycemicIndex = v;
        bus.sampleValid   = 1'b1;
        @(posedge clk);
        #1;
        bus.sampleValid   = 1'b0;
    endtask

    // Called just after the confirming edge: measures pump width and lockout length.
    task automatic run_dose(input string tag, input bit ins, input int exp_len);
        int n = 0;
        int m = 0;
        bit other = 1'b0;
        while ((ins ? bus.insulinPump : bus.glucagonPump) && n < 300) begin
            if (ins ? bus.glucagonPump : bus.insulinPump) other = 1'b1;
            n++;
            tick(1);
        end
        chk({tag, " pump_len"}, n, exp_len);
        chk({tag, " other_pump"}, 32'(other), 0);
        while (bus.busy && m < 300) begin
            m++;
            tick(1);
        end
        chk({tag, " lockout_len"}, m, 16);
    endtask

    task automatic wait_idle();
        int m = 0;
        while (bus.busy && m < 100) begin
            m++;
            tick(1);
        end
        if (m >= 100) chk("idle_timeout", 32'(bus.busy), 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.glycemicIndex = 4'd0;
        bus.sampleValid   = 1'b0;
        tick(2);
        chk("rst insulin", 32'(bus.insulinPump), 0);
        chk("rst glucagon", 32'(bus.glucagonPump), 0);
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst alarm", 32'(bus.alarm), 0);
        chk("rst count", 32'(bus.doseCount), 0);
        @(negedge clk);
        reset = 1'b0;

        // 12 at edge 1, 12 at edge 3: insulin 4 cycles, lockout 16
        sample(4'd12);
        chk("t1 armed pump", 32'(bus.insulinPump), 0);
        chk("t1 armed busy", 32'(bus.busy), 0);
        tick(1);
        sample(4'd12);
        chk("t1 busy", 32'(bus.busy), 1);
        chk("t1 count", 32'(bus.doseCount), 1);
        run_dose("t1", 1'b1, 4);

        // 0,0: glucagon 16 cycles, alarm from first sample, cleared by 7
        sample(4'd0);
        chk("t2 alarm set", 32'(bus.alarm), 1);
        sample(4'd0);
        chk("t2 count", 32'(bus.doseCount), 2);
        run_dose("t2", 1'b0, 16);
        chk("t2 alarm hold", 32'(bus.alarm), 1);
        sample(4'd7);
        chk("t2 alarm clr", 32'(bus.alarm), 0);

        // 13,7,13: no dose, left ARMED(HIGH); another 13 confirms an 8-cycle insulin dose
        sample(4'd13);
        sample(4'd7);
        sample(4'd13);
        chk("t3 no pump", 32'(bus.insulinPump), 0);
        chk("t3 not busy", 32'(bus.busy), 0);
        sample(4'd13);
        chk("t3 armed confirm", 32'(bus.insulinPump), 1);
        run_dose("t3", 1'b1, 8);

        // 14,2,2: class replaced, glucagon (3-2+1)*4 = 8
        sample(4'd14);
        sample(4'd2);
        chk("t4 replaced no pump", 32'(bus.glucagonPump | bus.insulinPump), 0);
        sample(4'd2);
        chk("t4 count", 32'(bus.doseCount), 4);
        run_dose("t4", 1'b0, 8);

        // 15,15 with samples 0 and 12 during the dose: length unchanged, no re-arm
        sample(4'd15);
        sample(4'd15);
        chk("t5 alarm", 32'(bus.alarm), 1);
        chk("t5 pump", 32'(bus.insulinPump), 1);
        sample(4'd0);
        sample(4'd12);
        chk("t5 alarm hold", 32'(bus.alarm), 1);
        chk("t5 count", 32'(bus.doseCount), 5);
        run_dose("t5 rem", 1'b1, 14);
        sample(4'd12);
        chk("t5 no rearm", 32'(bus.insulinPump), 0);
        chk("t5 no rearm busy", 32'(bus.busy), 0);
        sample(4'd7);

        // Asynchronous reset 2 cycles into an insulin dose
        sample(4'd15);
        sample(4'd15);
        tick(2);
        chk("t6 pre pump", 32'(bus.insulinPump), 1);
        chk("t6 pre alarm", 32'(bus.alarm), 1);
        reset = 1'b1;
        #1;
        chk("t6 pump drop", 32'(bus.insulinPump), 0);
        chk("t6 busy", 32'(bus.busy), 0);
        chk("t6 alarm", 32'(bus.alarm), 0);
        chk("t6 count", 32'(bus.doseCount), 0);
        chk("t6 glucagon", 32'(bus.glucagonPump), 0);
        @(negedge clk);
        reset = 1'b0;

        // Saturation: 256 doses of 12,12
        for (int i = 0; i < 256; i++) begin
            sample(4'd12);
            sample(4'd12);
            wait_idle();
            if (i == 253) chk("sat 254", 32'(bus.doseCount), 254);
            if (i == 254) chk("sat 255", 32'(bus.doseCount), 255);
        end
        chk("sat hold", 32'(bus.doseCount), 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
